// File: rtl/line_fetch_responder.sv
// line_fetch_responder
//   Memory-side responder for the fetch read_req/read_done handshake. A request
//   carries a PC. The block returns the cache line that contains that PC. The line
//   comes from a one-entry line buffer on a hit. On a miss it comes from a
//   BEATS-long burst on the instruction memory port.
//
// Ports
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   flush_i            fetch flush; abandons any in-flight read
//   read_req_i         one-cycle read request (honoured only when idle)
//   read_addr_i        request PC; the offset bits are ignored
//   read_done_o        one-cycle pulse; read_line_o is valid for the last request
//   read_line_o        returned line (registered)
//   mem_req_valid_o    burst request valid; held until mem_req_ready_i
//   mem_req_ready_i    memory accepts the burst request
//   mem_req_addr_o     line-aligned burst base address
//   mem_rsp_valid_i    response beat valid (memory never stalls on it)
//   mem_rsp_data_i     beat data; beat k lands in line bits [k*MEM_W +: MEM_W]
module line_fetch_responder #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int MEM_W  = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              read_req_i,
  input  logic [ADDR_W-1:0] read_addr_i,
  output logic              read_done_o,
  output logic [LINE_W-1:0] read_line_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  input  logic              mem_rsp_valid_i,
  input  logic [MEM_W-1:0]  mem_rsp_data_i
);

  localparam int BEATS = LINE_W / MEM_W;
  localparam int OFF   = $clog2(LINE_W / 8);
  localparam int TAG_W = ADDR_W - OFF;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HIT, S_MEM_REQ, S_MEM_RSP, S_DONE, S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [TAG_W-1:0]   req_tag_q, req_tag_d;
  logic               buf_valid_q, buf_valid_d;
  logic [TAG_W-1:0]   buf_tag_q, buf_tag_d;
  logic [LINE_W-1:0]  buf_data_q, buf_data_d;
  logic [LINE_W-1:0]  fill_q, fill_d;
  logic [LINE_W-1:0]  line_q, line_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               aborted_q, aborted_d;
  // Set when a flush coincides with the final beat: DRAIN has nothing left to eat.
  logic               drain_empty_q, drain_empty_d;

  logic [TAG_W-1:0]   addr_tag;
  logic [LINE_W-1:0]  beat_fill;
  logic               last_beat;
  logic               unused_addr_bits;

  assign addr_tag         = read_addr_i[ADDR_W-1:OFF];
  assign unused_addr_bits = ^read_addr_i[OFF-1:0];
  assign last_beat        = mem_rsp_valid_i && (cnt_q == LAST_BEAT);
  assign read_line_o      = line_q;
  assign mem_req_addr_o   = {req_tag_q, {OFF{1'b0}}};

  // Fill register with the current beat merged into its slot.
  always_comb begin
    beat_fill = fill_q;
    for (int k = 0; k < BEATS; k++) begin
      if (cnt_q == CNT_W'(k)) begin
        beat_fill[k*MEM_W +: MEM_W] = mem_rsp_data_i;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    req_tag_d       = req_tag_q;
    buf_valid_d     = buf_valid_q;
    buf_tag_d       = buf_tag_q;
    buf_data_d      = buf_data_q;
    fill_d          = fill_q;
    line_d          = line_q;
    cnt_d           = cnt_q;
    aborted_d       = aborted_q;
    drain_empty_d   = drain_empty_q;
    read_done_o     = 1'b0;
    mem_req_valid_o = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (read_req_i && !flush_i) begin
          req_tag_d     = addr_tag;
          aborted_d     = 1'b0;
          drain_empty_d = 1'b0;
          if (buf_valid_q && (buf_tag_q == addr_tag)) begin
            // Load the output line on entry so it is valid in the pulse cycle.
            state_d = S_HIT;
            line_d  = buf_data_q;
          end else begin
            state_d = S_MEM_REQ;
          end
        end
      end

      S_HIT: begin
        read_done_o = !flush_i;
        state_d     = S_IDLE;
      end

      S_MEM_REQ: begin
        // Valid stays up through a flush; a posted request cannot be withdrawn.
        mem_req_valid_o = 1'b1;
        if (flush_i) begin
          aborted_d = 1'b1;
        end
        if (mem_req_ready_i) begin
          cnt_d   = '0;
          state_d = (aborted_q || flush_i) ? S_DRAIN : S_MEM_RSP;
        end
      end

      S_MEM_RSP: begin
        if (mem_rsp_valid_i) begin
          fill_d = beat_fill;
          cnt_d  = last_beat ? '0 : cnt_q + 1'b1;
        end
        if (flush_i) begin
          aborted_d     = 1'b1;
          drain_empty_d = last_beat;
          state_d       = S_DRAIN;
        end else if (last_beat) begin
          line_d  = beat_fill;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // The fill data is complete even under flush, so the buffer is refreshed.
        buf_valid_d = 1'b1;
        buf_tag_d   = req_tag_q;
        buf_data_d  = fill_q;
        read_done_o = !flush_i;
        state_d     = S_IDLE;
      end

      S_DRAIN: begin
        if (drain_empty_q) begin
          state_d = S_IDLE;
        end else if (mem_rsp_valid_i) begin
          if (last_beat) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= S_IDLE;
      req_tag_q     <= '0;
      buf_valid_q   <= 1'b0;
      buf_tag_q     <= '0;
      buf_data_q    <= '0;
      fill_q        <= '0;
      line_q        <= '0;
      cnt_q         <= '0;
      aborted_q     <= 1'b0;
      drain_empty_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      req_tag_q     <= req_tag_d;
      buf_valid_q   <= buf_valid_d;
      buf_tag_q     <= buf_tag_d;
      buf_data_q    <= buf_data_d;
      fill_q        <= fill_d;
      line_q        <= line_d;
      cnt_q         <= cnt_d;
      aborted_q     <= aborted_d;
      drain_empty_q <= drain_empty_d;
    end
  end

endmodule

// File: tb/tb_line_fetch_responder.sv
// tb_line_fetch_responder
//   Directed bench for line_fetch_responder (ADDR_W=32, LINE_W=128, MEM_W=32).
//   Inputs are driven 1 time unit after the rising edge. Outputs are checked
//   1 unit later, inside the same cycle.
module tb_line_fetch_responder;

  logic         clk_i = 1'b0;
  logic         rst_n_i;
  logic         flush_i;
  logic         read_req_i;
  logic [31:0]  read_addr_i;
  logic         read_done_o;
  logic [127:0] read_line_o;
  logic         mem_req_valid_o;
  logic         mem_req_ready_i;
  logic [31:0]  mem_req_addr_o;
  logic         mem_rsp_valid_i;
  logic [31:0]  mem_rsp_data_i;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] LINE_1000 = 128'h0000000D_0000000C_0000000B_0000000A;
  localparam logic [127:0] LINE_2000 = 128'h000002A3_000002A2_000002A1_000002A0;
  localparam logic [127:0] LINE_3000 = 128'h00000044_00000033_00000022_00000011;
  localparam logic [127:0] LINE_7000 = 128'h00000074_00000073_00000072_00000071;

  line_fetch_responder #(.ADDR_W(32), .LINE_W(128), .MEM_W(32)) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .flush_i         (flush_i),
    .read_req_i      (read_req_i),
    .read_addr_i     (read_addr_i),
    .read_done_o     (read_done_o),
    .read_line_o     (read_line_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_rsp_valid_i (mem_rsp_valid_i),
    .mem_rsp_data_i  (mem_rsp_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Advance to the next cycle and return all strobes to their idle level.
  task automatic tick();
    @(posedge clk_i);
    #1;
    flush_i         = 1'b0;
    read_req_i      = 1'b0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i  = '0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    flush_i = 1'b0; read_req_i = 1'b0; read_addr_i = '0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
    repeat (2) @(posedge clk_i);
    #2;
    total++;
    if ({read_done_o, mem_req_valid_o, read_line_o, mem_req_addr_o} !== '0) begin
      bad++;
      $display("FAIL reset_in outputs done=%0b valid=%0b line=%h addr=%h want all 0",
               read_done_o, mem_req_valid_o, read_line_o, mem_req_addr_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    tick();
    #1;
    total++;
    if ({read_done_o, mem_req_valid_o, read_line_o, mem_req_addr_o} !== '0) begin
      bad++;
      $display("FAIL reset_out outputs done=%0b valid=%0b line=%h addr=%h want all 0",
               read_done_o, mem_req_valid_o, read_line_o, mem_req_addr_o);
    end
    $display("reset: checked outputs during and after reset");
  endtask

  task automatic test_cold_miss();
    logic [31:0] beat [4];
    beat[0] = 32'hA; beat[1] = 32'hB; beat[2] = 32'hC; beat[3] = 32'hD;
    tick();
    read_req_i = 1'b1; read_addr_i = 32'h1004;
    #1;
    total++;
    if ({read_done_o, mem_req_valid_o} !== 2'b00) begin
      bad++; $display("FAIL cold_req_cycle done/valid=%b want 00", {read_done_o, mem_req_valid_o});
    end
    tick();
    mem_req_ready_i = 1'b1;
    #1;
    total++;
    if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h1000) begin
      bad++; $display("FAIL cold_mem_req valid=%0b addr=%h want 1 00001000", mem_req_valid_o, mem_req_addr_o);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      mem_rsp_valid_i = 1'b1; mem_rsp_data_i = beat[k];
      #1;
      total++;
      if ({read_done_o, mem_req_valid_o} !== 2'b00) begin
        bad++; $display("FAIL cold_beat%0d done/valid=%b want 00", k, {read_done_o, mem_req_valid_o});
      end
    end
    tick();
    #1;
    total++;
    if (read_done_o !== 1'b1 || read_line_o !== LINE_1000) begin
      bad++; $display("FAIL cold_done done=%0b line=%h want 1 %h", read_done_o, read_line_o, LINE_1000);
    end
    tick();
    #1;
    total++;
    if (read_done_o !== 1'b0 || read_line_o !== LINE_1000) begin
      bad++; $display("FAIL cold_after done=%0b line=%h want 0 %h", read_done_o, read_line_o, LINE_1000);
    end
    $display("cold_miss: req 0x1004 line=%h", read_line_o);
  endtask

  task automatic test_hit();
    tick();
    read_req_i = 1'b1; read_addr_i = 32'h100C;
    #1;
    tick();
    #1;
    total++;
    if (read_done_o !== 1'b1 || read_line_o !== LINE_1000 || mem_req_valid_o !== 1'b0) begin
      bad++; $display("FAIL hit_done done=%0b line=%h valid=%0b want 1 %h 0",
                      read_done_o, read_line_o, mem_req_valid_o, LINE_1000);
    end
    tick();
    #1;
    total++;
    if ({read_done_o, mem_req_valid_o} !== 2'b00) begin
      bad++; $display("FAIL hit_after done/valid=%b want 00", {read_done_o, mem_req_valid_o});
    end
    $display("hit: req 0x100C line=%h", read_line_o);
  endtask

  task automatic test_flush_same_cycle_req();
    tick();
    read_req_i = 1'b1; flush_i = 1'b1; read_addr_i = 32'h5000;
    #1;
    for (int k = 0; k < 2; k++) begin
      tick();
      #1;
      total++;
      if ({read_done_o, mem_req_valid_o} !== 2'b00) begin
        bad++; $display("FAIL flushreq_c%0d done/valid=%b want 00", k, {read_done_o, mem_req_valid_o});
      end
    end
    $display("flush_same_cycle_req: req 0x5000 dropped");
  endtask

  task automatic test_flush_mid_burst();
    tick();
    read_req_i = 1'b1; read_addr_i = 32'h2000;
    tick();
    mem_req_ready_i = 1'b1;
    tick();
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h21;
    tick();
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h22; flush_i = 1'b1;
    for (int k = 2; k < 4; k++) begin
      tick();
      mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h20 + k;
      #1;
      total++;
      if ({read_done_o, mem_req_valid_o} !== 2'b00) begin
        bad++; $display("FAIL midflush_drain%0d done/valid=%b want 00", k, {read_done_o, mem_req_valid_o});
      end
    end
    // Drain finished: the idle block should now hit on the untouched 0x1000 line.
    tick();
    read_req_i = 1'b1; read_addr_i = 32'h1000;
    #1;
    total++;
    if (read_done_o !== 1'b0 || read_line_o !== LINE_1000) begin
      bad++; $display("FAIL midflush_no_done done=%0b line=%h want 0 %h", read_done_o, read_line_o, LINE_1000);
    end
    tick();
    #1;
    total++;
    if (read_done_o !== 1'b1 || read_line_o !== LINE_1000 || mem_req_valid_o !== 1'b0) begin
      bad++; $display("FAIL midflush_rehit done=%0b line=%h valid=%0b want 1 %h 0",
                      read_done_o, read_line_o, mem_req_valid_o, LINE_1000);
    end
    tick();
    read_req_i = 1'b1; read_addr_i = 32'h2000;
    tick();
    mem_req_ready_i = 1'b1;
    #1;
    total++;
    if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h2000) begin
      bad++; $display("FAIL midflush_remiss valid=%0b addr=%h want 1 00002000", mem_req_valid_o, mem_req_addr_o);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h2A0 + k;
    end
    tick();
    #1;
    total++;
    if (read_done_o !== 1'b1 || read_line_o !== LINE_2000) begin
      bad++; $display("FAIL midflush_refill done=%0b line=%h want 1 %h", read_done_o, read_line_o, LINE_2000);
    end
    $display("flush_mid_burst: 0x2000 drained then refetched line=%h", read_line_o);
  endtask

  task automatic test_flush_in_mem_req();
    tick();
    read_req_i = 1'b1; read_addr_i = 32'h4000;
    tick();
    flush_i = 1'b1;
    #1;
    total++;
    if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h4000 || read_done_o !== 1'b0) begin
      bad++; $display("FAIL reqflush_flushcyc valid=%0b addr=%h done=%0b want 1 00004000 0",
                      mem_req_valid_o, mem_req_addr_o, read_done_o);
    end
    tick();
    #1;
    total++;
    if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h4000) begin
      bad++; $display("FAIL reqflush_held valid=%0b addr=%h want 1 00004000", mem_req_valid_o, mem_req_addr_o);
    end
    tick();
    mem_req_ready_i = 1'b1;
    #1;
    total++;
    if (mem_req_valid_o !== 1'b1) begin
      bad++; $display("FAIL reqflush_accept valid=%0b want 1", mem_req_valid_o);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h40 + k;
      #1;
      total++;
      if ({read_done_o, mem_req_valid_o} !== 2'b00) begin
        bad++; $display("FAIL reqflush_drain%0d done/valid=%b want 00", k, {read_done_o, mem_req_valid_o});
      end
    end
    // All four beats drained: back in idle, so the 0x2000 line hits next cycle.
    tick();
    read_req_i = 1'b1; read_addr_i = 32'h2008;
    #1;
    total++;
    if (read_done_o !== 1'b0) begin
      bad++; $display("FAIL reqflush_no_done done=%0b want 0", read_done_o);
    end
    tick();
    #1;
    total++;
    if (read_done_o !== 1'b1 || read_line_o !== LINE_2000) begin
      bad++; $display("FAIL reqflush_rehit done=%0b line=%h want 1 %h", read_done_o, read_line_o, LINE_2000);
    end
    $display("flush_in_mem_req: 0x4000 drained, 0x2008 hit line=%h", read_line_o);
  endtask

  task automatic test_backpressure();
    tick();
    read_req_i = 1'b1; read_addr_i = 32'h3008;
    for (int k = 0; k < 5; k++) begin
      tick();
      #1;
      total++;
      if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h3000) begin
        bad++; $display("FAIL bp_wait%0d valid=%0b addr=%h want 1 00003000", k, mem_req_valid_o, mem_req_addr_o);
      end
    end
    tick();
    mem_req_ready_i = 1'b1;
    #1;
    total++;
    if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h3000) begin
      bad++; $display("FAIL bp_accept valid=%0b addr=%h want 1 00003000", mem_req_valid_o, mem_req_addr_o);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h11 * (k + 1);
      #1;
      total++;
      if ({read_done_o, mem_req_valid_o} !== 2'b00) begin
        bad++; $display("FAIL bp_beat%0d done/valid=%b want 00", k, {read_done_o, mem_req_valid_o});
      end
    end
    tick();
    #1;
    total++;
    if (read_done_o !== 1'b1 || read_line_o !== LINE_3000) begin
      bad++; $display("FAIL bp_done done=%0b line=%h want 1 %h", read_done_o, read_line_o, LINE_3000);
    end
    $display("backpressure: req 0x3008 line=%h", read_line_o);
  endtask

  task automatic test_reset_mid_burst();
    tick();
    read_req_i = 1'b1; read_addr_i = 32'h6000;
    tick();
    mem_req_ready_i = 1'b1;
    tick();
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h61;
    tick();
    mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h62;
    @(negedge clk_i);
    rst_n_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    #1;
    total++;
    if ({read_done_o, mem_req_valid_o, read_line_o, mem_req_addr_o} !== '0) begin
      bad++; $display("FAIL rstmid_async done=%0b valid=%0b line=%h addr=%h want all 0",
                      read_done_o, mem_req_valid_o, read_line_o, mem_req_addr_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    // 0x3000 was buffered before the reset; it must now miss.
    tick();
    read_req_i = 1'b1; read_addr_i = 32'h3004;
    tick();
    mem_req_ready_i = 1'b1;
    #1;
    total++;
    if (mem_req_valid_o !== 1'b1 || mem_req_addr_o !== 32'h3000 || read_done_o !== 1'b0) begin
      bad++; $display("FAIL rstmid_remiss valid=%0b addr=%h done=%0b want 1 00003000 0",
                      mem_req_valid_o, mem_req_addr_o, read_done_o);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      mem_rsp_valid_i = 1'b1; mem_rsp_data_i = 32'h71 + k;
    end
    tick();
    #1;
    total++;
    if (read_done_o !== 1'b1 || read_line_o !== LINE_7000) begin
      bad++; $display("FAIL rstmid_refill done=%0b line=%h want 1 %h", read_done_o, read_line_o, LINE_7000);
    end
    $display("reset_mid_burst: outputs cleared, 0x3004 refetched line=%h", read_line_o);
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_hit();
    test_flush_same_cycle_req();
    test_flush_mid_burst();
    test_flush_in_mem_req();
    test_backpressure();
    test_reset_mid_burst();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
